// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
//   - state_e : arbiter FSM states (idle, memory access, response)
//   - owner_e : grant owner encoding, CPU = 0, debug/loader = 1
//   - DataWidth / AddrWidth : bus widths (8 bits)
//   - other_owner() : returns the opposite port, used for round-robin ties
package dmem_arb_pkg;

  localparam int unsigned DataWidth = 8;
  localparam int unsigned AddrWidth = 8;

  typedef logic [DataWidth-1:0] data_t;
  typedef logic [AddrWidth-1:0] addr_t;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  typedef enum logic {
    OwnCpu = 1'b0,
    OwnDbg = 1'b1
  } owner_e;

  function automatic owner_e other_owner(owner_e o);
    return (o == OwnCpu) ? OwnDbg : OwnCpu;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters (CPU, debug/loader), the arbiter and the DMEM.
//   Cpu_* / Dbg_* : level request + write/addr/wdata in, one-cycle ack + rdata out
//   Mem_*         : DMEM address, write data, read/write strobes, combinational read data
//   Busy          : arbiter not idle
//   Grant_Owner   : 0 = CPU, 1 = debug; meaningful only while Busy = 1
// Modports: master = requester/memory side, slave = arbiter.
interface dmem_arbiter_if;
  import dmem_arb_pkg::*;

  logic  Cpu_Req;
  logic  Cpu_Write;
  addr_t Cpu_Addr;
  data_t Cpu_Wdata;
  logic  Cpu_Ack;
  data_t Cpu_Rdata;

  logic  Dbg_Req;
  logic  Dbg_Write;
  addr_t Dbg_Addr;
  data_t Dbg_Wdata;
  logic  Dbg_Ack;
  data_t Dbg_Rdata;

  addr_t Mem_Address;
  data_t Mem_Write_Data;
  logic  Mem_Read;
  logic  Mem_Write;
  data_t Mem_Read_Data;

  logic  Busy;
  logic  Grant_Owner;

  modport master (
    output Cpu_Req, Cpu_Write, Cpu_Addr, Cpu_Wdata,
    input  Cpu_Ack, Cpu_Rdata,
    output Dbg_Req, Dbg_Write, Dbg_Addr, Dbg_Wdata,
    input  Dbg_Ack, Dbg_Rdata,
    input  Mem_Address, Mem_Write_Data, Mem_Read, Mem_Write,
    output Mem_Read_Data,
    input  Busy, Grant_Owner
  );

  modport slave (
    input  Cpu_Req, Cpu_Write, Cpu_Addr, Cpu_Wdata,
    output Cpu_Ack, Cpu_Rdata,
    input  Dbg_Req, Dbg_Write, Dbg_Addr, Dbg_Wdata,
    output Dbg_Ack, Dbg_Rdata,
    output Mem_Address, Mem_Write_Data, Mem_Read, Mem_Write,
    input  Mem_Read_Data,
    output Busy, Grant_Owner
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// Winner selection for the data-memory arbiter (purely combinational).
//   cpu_req, dbg_req : pending requests sampled in idle
//   last_served      : port granted most recently
//   winner           : port to grant; only meaningful when a request is present
// Build option: DMEM_ARB_RR_EN defined -> ties go to the port not served last;
// otherwise ties always go to the CPU and last_served is ignored.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic   cpu_req,
  input  logic   dbg_req,
  input  owner_e last_served,
  output owner_e winner
);

  owner_e tie_winner;

`ifdef DMEM_ARB_RR_EN
  assign tie_winner = other_owner(last_served);
`else
  logic unused_last;
  assign unused_last = last_served;
  assign tie_winner  = OwnCpu;
`endif

  always_comb begin
    winner = OwnCpu;
    if (cpu_req && dbg_req) begin
      winner = tie_winner;
    end else if (dbg_req) begin
      winner = OwnDbg;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU and debug/loader share one single-port DMEM.
// Each access takes idle -> access -> response, i.e. at most one access every 3 cycles.
//   Clk_O : system clock, all state on the rising edge
//   Reset : asynchronous active-high reset
//   bus   : dmem_arbiter_if.slave (requester ports, DMEM port, Busy, Grant_Owner)
// Build option: DMEM_ARB_RR_EN selects round-robin tie-breaking (default: CPU priority).
module dmem_arbiter
  import dmem_arb_pkg::*;
(
  input logic          Clk_O,
  input logic          Reset,
  dmem_arbiter_if.slave bus
);

  state_e state_q;
  owner_e owner_q;
  logic   write_q;
  addr_t  addr_q;
  data_t  wdata_q;
  logic   mem_rd_q;
  logic   mem_wr_q;
  logic   cpu_ack_q;
  logic   dbg_ack_q;
  data_t  cpu_rdata_q;
  data_t  dbg_rdata_q;

  owner_e winner;
  owner_e last_served;
  logic   any_req;

  assign any_req = bus.Cpu_Req | bus.Dbg_Req;

`ifdef DMEM_ARB_RR_EN
  owner_e last_q;
  assign last_served = last_q;

  // Pointer moves when a grant is taken; reset value makes the first tie go to the CPU.
  always_ff @(posedge Clk_O or posedge Reset) begin
    if (Reset) begin
      last_q <= OwnDbg;
    end else if (state_q == StIdle && any_req) begin
      last_q <= winner;
    end
  end
`else
  assign last_served = OwnDbg;
`endif

  dmem_arb_pick u_pick (
    .cpu_req     (bus.Cpu_Req),
    .dbg_req     (bus.Dbg_Req),
    .last_served (last_served),
    .winner      (winner)
  );

  // FSM with registered strobes, acks and read-data holding registers.
  always_ff @(posedge Clk_O or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      owner_q     <= OwnCpu;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cpu_ack_q <= 1'b0;
          dbg_ack_q <= 1'b0;
          if (any_req) begin
            owner_q <= winner;
            state_q <= StAccess;
            if (winner == OwnDbg) begin
              write_q  <= bus.Dbg_Write;
              addr_q   <= bus.Dbg_Addr;
              wdata_q  <= bus.Dbg_Wdata;
              mem_wr_q <= bus.Dbg_Write;
              mem_rd_q <= ~bus.Dbg_Write;
            end else begin
              write_q  <= bus.Cpu_Write;
              addr_q   <= bus.Cpu_Addr;
              wdata_q  <= bus.Cpu_Wdata;
              mem_wr_q <= bus.Cpu_Write;
              mem_rd_q <= ~bus.Cpu_Write;
            end
          end
        end
        StAccess: begin
          // The DMEM commits a write on this same edge; reads are captured here.
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
          if (!write_q) begin
            if (owner_q == OwnDbg) begin
              dbg_rdata_q <= bus.Mem_Read_Data;
            end else begin
              cpu_rdata_q <= bus.Mem_Read_Data;
            end
          end
          cpu_ack_q <= (owner_q == OwnCpu);
          dbg_ack_q <= (owner_q == OwnDbg);
          state_q   <= StResp;
        end
        StResp: begin
          cpu_ack_q <= 1'b0;
          dbg_ack_q <= 1'b0;
          state_q   <= StIdle;
        end
        default: begin
          mem_rd_q  <= 1'b0;
          mem_wr_q  <= 1'b0;
          cpu_ack_q <= 1'b0;
          dbg_ack_q <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  // Address/data hold their latched values outside access; only the strobes gate the DMEM.
  assign bus.Mem_Address    = addr_q;
  assign bus.Mem_Write_Data = wdata_q;
  assign bus.Mem_Read       = mem_rd_q;
  assign bus.Mem_Write      = mem_wr_q;
  assign bus.Cpu_Ack        = cpu_ack_q;
  assign bus.Dbg_Ack        = dbg_ack_q;
  assign bus.Cpu_Rdata      = cpu_rdata_q;
  assign bus.Dbg_Rdata      = dbg_rdata_q;
  assign bus.Busy           = (state_q != StIdle);
  assign bus.Grant_Owner    = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized two-port traffic,
// checked against a transaction-level model (reference memory, last-read values per port,
// tie-break rule). Honours DMEM_ARB_RR_EN for the expected tie winner.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic clk;
  logic rst;

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .Clk_O (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Environment DMEM: combinational read, write on rising edge while Mem_Write is high.
  logic [7:0] dmem [256];
  assign bus.Mem_Read_Data = dmem[bus.Mem_Address];
  always @(posedge clk) begin
    if (bus.Mem_Write) dmem[bus.Mem_Address] = bus.Mem_Write_Data;
  end

  // Reference model state.
  logic [7:0] ref_mem [256];
  logic [7:0] exp_cpu_rd;
  logic [7:0] exp_dbg_rd;
  bit         last_srv;    // 0 = CPU, 1 = DBG

  // Pending request per port (held until its ack).
  bit         cpu_p, dbg_p, cpu_w, dbg_w;
  logic [7:0] cpu_a, dbg_a, cpu_d, dbg_d;

  int vectors;
  int miscompares;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive();
    bus.Cpu_Req   = cpu_p;
    bus.Cpu_Write = cpu_w;
    bus.Cpu_Addr  = cpu_a;
    bus.Cpu_Wdata = cpu_d;
    bus.Dbg_Req   = dbg_p;
    bus.Dbg_Write = dbg_w;
    bus.Dbg_Addr  = dbg_a;
    bus.Dbg_Wdata = dbg_d;
  endtask

  function automatic bit model_winner(bit c, bit d, bit last);
    if (c && d) return RrEn ? !last : 1'b0;
    return d;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, " busy"}, bus.Busy, 0);
    check({tag, " rd"}, bus.Mem_Read, 0);
    check({tag, " wr"}, bus.Mem_Write, 0);
    check({tag, " cack"}, bus.Cpu_Ack, 0);
    check({tag, " dack"}, bus.Dbg_Ack, 0);
  endtask

  // Called at a negedge in idle with requests driven; walks one full transaction.
  task automatic serve(input string tag, input bit drop_winner);
    bit         win, w;
    logic [7:0] a, d;
    win = model_winner(cpu_p, dbg_p, last_srv);
    w   = win ? dbg_w : cpu_w;
    a   = win ? dbg_a : cpu_a;
    d   = win ? dbg_d : cpu_d;
    step();
    check({tag, " acc busy"}, bus.Busy, 1);
    check({tag, " acc owner"}, bus.Grant_Owner, win);
    check({tag, " acc rd"}, bus.Mem_Read, !w);
    check({tag, " acc wr"}, bus.Mem_Write, w);
    check({tag, " acc addr"}, bus.Mem_Address, a);
    check({tag, " acc cack"}, bus.Cpu_Ack, 0);
    check({tag, " acc dack"}, bus.Dbg_Ack, 0);
    if (w) check({tag, " acc wdata"}, bus.Mem_Write_Data, d);
    step();
    if (w) ref_mem[a] = d;
    else if (win) exp_dbg_rd = ref_mem[a];
    else exp_cpu_rd = ref_mem[a];
    last_srv = win;
    check({tag, " rsp busy"}, bus.Busy, 1);
    check({tag, " rsp cack"}, bus.Cpu_Ack, !win);
    check({tag, " rsp dack"}, bus.Dbg_Ack, win);
    check({tag, " rsp crdata"}, bus.Cpu_Rdata, exp_cpu_rd);
    check({tag, " rsp drdata"}, bus.Dbg_Rdata, exp_dbg_rd);
    check({tag, " rsp rd"}, bus.Mem_Read, 0);
    check({tag, " rsp wr"}, bus.Mem_Write, 0);
    if (w) check({tag, " commit"}, dmem[a], d);
    if (drop_winner) begin
      if (win) dbg_p = 0;
      else cpu_p = 0;
      drive();
    end
    step();
    check_quiet({tag, " idle"});
  endtask

  task automatic do_reset(input string tag);
    rst   = 1'b1;
    cpu_p = 0;
    dbg_p = 0;
    drive();
    step();
    step();
    exp_cpu_rd = 8'h00;
    exp_dbg_rd = 8'h00;
    last_srv   = 1'b1;
    check_quiet(tag);
    check({tag, " owner"}, bus.Grant_Owner, 0);
    check({tag, " addr"}, bus.Mem_Address, 8'h00);
    check({tag, " wdata"}, bus.Mem_Write_Data, 8'h00);
    check({tag, " crdata"}, bus.Cpu_Rdata, 8'h00);
    check({tag, " drdata"}, bus.Dbg_Rdata, 8'h00);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] old5;
    clk = 1'b0;
    rst = 1'b1;
    vectors = 0;
    miscompares = 0;
    cpu_p = 0; dbg_p = 0; cpu_w = 0; dbg_w = 0;
    cpu_a = 0; dbg_a = 0; cpu_d = 0; dbg_d = 0;
    drive();
    for (int i = 0; i < 256; i++) begin
      dmem[i]    = 8'($urandom);
      ref_mem[i] = dmem[i];
    end
    dmem[8'h10]    = 8'h5A;
    ref_mem[8'h10] = 8'h5A;

    do_reset("reset");

    // CPU read alone.
    cpu_p = 1; cpu_w = 0; cpu_a = 8'h10; cpu_d = 8'h00;
    drive();
    serve("cpu_read", 1);
    check("cpu_read value", bus.Cpu_Rdata, 8'h5A);

    // Debug write then CPU read of the same location.
    dbg_p = 1; dbg_w = 1; dbg_a = 8'h20; dbg_d = 8'h3C;
    drive();
    serve("dbg_write", 1);
    check("dbg_write cpu rdata kept", bus.Cpu_Rdata, 8'h5A);
    cpu_p = 1; cpu_w = 0; cpu_a = 8'h20;
    drive();
    serve("cpu_read2", 1);
    check("cpu_read2 value", bus.Cpu_Rdata, 8'h3C);

    // Randomized traffic on a small address window so reads hit earlier writes.
    for (int t = 0; t < 80; t++) begin
      if (!cpu_p && $urandom_range(0, 2) != 0) begin
        cpu_p = 1; cpu_w = 1'($urandom_range(0, 1));
        cpu_a = 8'($urandom_range(0, 15)); cpu_d = 8'($urandom);
      end
      if (!dbg_p && $urandom_range(0, 2) != 0) begin
        dbg_p = 1; dbg_w = 1'($urandom_range(0, 1));
        dbg_a = 8'($urandom_range(0, 15)); dbg_d = 8'($urandom);
      end
      drive();
      if (!cpu_p && !dbg_p) begin
        step();
        check_quiet("rand none");
      end else begin
        serve("rand", 1);
      end
    end

    // Both requests held continuously: four grants, acks every 3 cycles.
    do_reset("reset2");
    cpu_p = 1; cpu_w = 0; cpu_a = 8'h20;
    dbg_p = 1; dbg_w = 0; dbg_a = 8'h10;
    drive();
    for (int g = 0; g < 4; g++) begin
      check("tie grant order", model_winner(cpu_p, dbg_p, last_srv),
            RrEn ? 1'(g % 2) : 1'b0);
      serve("tie", g == 3);
    end
    cpu_p = 0; dbg_p = 0;
    drive();
    step();
    check_quiet("tie drained");

    // CPU request held 9 cycles: acks at cycles 2, 5, 8.
    cpu_p = 1; cpu_w = 0; cpu_a = 8'h05;
    drive();
    serve("b2b0", 0);
    serve("b2b1", 0);
    serve("b2b2", 1);
    step();
    check_quiet("b2b after");

    // Reset during the access phase of a write.
    old5  = ref_mem[8'h05];
    cpu_p = 1; cpu_w = 1; cpu_a = 8'h05; cpu_d = 8'hFF;
    drive();
    step();
    check("midrst acc wr", bus.Mem_Write, 1);
    rst = 1'b1;
    #1;
    check("midrst wr drop", bus.Mem_Write, 0);
    check("midrst rd drop", bus.Mem_Read, 0);
    check("midrst busy", bus.Busy, 0);
    check("midrst addr", bus.Mem_Address, 8'h00);
    check("midrst wdata", bus.Mem_Write_Data, 8'h00);
    check("midrst crdata", bus.Cpu_Rdata, 8'h00);
    cpu_p = 0;
    drive();
    step();
    check("midrst no commit", dmem[8'h05], old5);
    rst = 1'b0;
    exp_cpu_rd = 8'h00;
    exp_dbg_rd = 8'h00;
    last_srv   = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check_quiet("midrst after");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have ports: Clk_O  in  1  system clock, all state on rising edge; reset is asynchronous and active-high.
REQ-002 SHALL have: Reset  in  1  asynchronous active-high reset.
REQ-003 SHALL have: Cpu_Req  in  1  CPU access request, level, held until Cpu_Ack.
REQ-004 SHALL have: Cpu_Write  in  1  1=write, 0=read; stable while Cpu_Req high.
REQ-005 SHALL have: Cpu_Addr / Cpu_Wdata  in  8 / 8  CPU address and write data; stable while Cpu_Req high.
REQ-006 SHALL have: Cpu_Ack  out  1  one-cycle completion pulse; Cpu_Rdata  out  8  read data, valid while Cpu_Ack=1.
REQ-007 SHALL have: Dbg_Req, Dbg_Write, Dbg_Addr[7:0], Dbg_Wdata[7:0] in; Dbg_Ack, Dbg_Rdata[7:0] out; debug/loader port, same rules as CPU port.
REQ-008 SHALL have: Mem_Address, Mem_Write_Data  out  8  to DMEM Address/Write_Data; Mem_Read, Mem_Write  out  1  DMEM strobes; Mem_Read_Data  in  8  from DMEM Read_Data (combinational read).
REQ-009 SHALL have: Busy  out  1  state != IDLE; Grant_Owner  out  1  0=CPU, 1=DBG, meaningful only when Busy=1.

Function
REQ-010 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; one access per 3 cycles max.
REQ-011 In IDLE with any Req high, SHALL at next edge latch winner's Write/Addr/Wdata, set Grant_Owner, enter ACCESS.
REQ-012 In IDLE with no Req, SHALL remain IDLE; strobes 0.
REQ-013 In ACCESS, SHALL drive Mem_Address/Mem_Write_Data from latched values; Mem_Write=latched Write, Mem_Read=!latched Write; exactly one strobe high.
REQ-014 DMEM write SHALL commit on the edge ending ACCESS; on that edge a read SHALL capture Mem_Read_Data into owner's Rdata register.
REQ-015 In RESP, SHALL assert owner's Ack for exactly one cycle; other Ack 0; strobes 0; then IDLE unconditionally.
REQ-016 Req SHALL be sampled only in IDLE; Req high in IDLE after an Ack is a new request (back-to-back allowed).
REQ-017 Rdata of each port SHALL hold its last read value until the next read by that port; a write SHALL leave it unchanged.
REQ-018 Mem_Address/Mem_Write_Data SHALL hold latched values outside ACCESS; only strobes gate DMEM.
REQ-019 Tie (both Req in IDLE): winner per Configuration; loser's request stays pending and is served next IDLE.

Reset
REQ-020 Reset SHALL asynchronously force IDLE; Cpu_Ack=Dbg_Ack=0, Mem_Read=Mem_Write=0, Busy=0, Grant_Owner=0, all 8-bit outputs 8'h00, last-served pointer=DBG.
REQ-021 Reset during ACCESS SHALL drop strobes immediately; the in-flight write is not committed; no Ack issued after release.

Configuration
REQ-022 With DMEM_ARB_RR_EN defined, ties SHALL go to the port not served last (round-robin; pointer updates on entering ACCESS); first tie after reset goes to CPU.
REQ-023 Without DMEM_ARB_RR_EN, ties SHALL always go to CPU (fixed priority); pointer logic absent.

Structure
REQ-024 Shared package dmem_arb_pkg SHALL hold state encoding (IDLE/ACCESS/RESP), owner encoding (OWN_CPU=0, OWN_DBG=1), data/address width constant 8.
REQ-025 Winner selection SHALL be one sub-module dmem_arb_pick (inputs two Reqs and last-served, output winner); FSM and datapath stay in dmem_arbiter.

Verification
REQ-026 CPU read alone: DMEM[8'h10]=8'h5A, Cpu_Req/Addr=8'h10 at IDLE -> Mem_Read=1 cycle 1, Cpu_Ack=1 with Cpu_Rdata=8'h5A cycle 2, Dbg_Ack=0.
REQ-027 Dbg write then CPU read: Dbg writes 8'h3C to 8'h20, then CPU reads 8'h20 -> Mem_Write exactly one cycle; Cpu_Rdata=8'h3C.
REQ-028 Simultaneous Req held continuously, RR_EN defined -> grants CPU, DBG, CPU, DBG; each Ack 3 cycles apart; without macro -> CPU every time, DBG starves.
REQ-029 Reset asserted mid-ACCESS of write 8'hFF to 8'h05 -> strobes drop same cycle, DMEM[8'h05] unchanged, no Ack, outputs 8'h00.
REQ-030 Back-to-back CPU Req kept high 9 cycles -> three Acks at cycles 2, 5, 8; Busy low only in IDLE cycles.
